// File: rtl/xiphos_pkg.sv
// Shared widths, channel types and channel indices
// for the registered 8-way word distributor.
package xiphos_pkg;

   localparam int WORD_W = 16;
   localparam int NCH    = 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [2:0]        chan_t;

   localparam chan_t CH_A = 3'd0;
   localparam chan_t CH_B = 3'd1;
   localparam chan_t CH_C = 3'd2;
   localparam chan_t CH_D = 3'd3;
   localparam chan_t CH_W = 3'd4;
   localparam chan_t CH_X = 3'd5;
   localparam chan_t CH_Y = 3'd6;
   localparam chan_t CH_Z = 3'd7;

endpackage

// File: rtl/dmux8way16_buf_if.sv
// Source-side and channel-side signals of the word distributor.
// The source drives the master modport; the distributor uses slave.
interface dmux8way16_buf_if
   import xiphos_pkg::*;
#(
   parameter int WIDTH = WORD_W
);

   logic [WIDTH-1:0] IN;
   chan_t            s;
   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A, B, C, D;
   logic [WIDTH-1:0] W, X, Y, Z;
   logic [NCH-1:0]   out_valid;
   logic [NCH-1:0]   out_ready;
   chan_t            ptr;

   modport master (
      output IN, s, mode, in_valid, out_ready,
      input  in_ready, A, B, C, D, W, X, Y, Z,
      input  out_valid, ptr
   );

   modport slave (
      input  IN, s, mode, in_valid, out_ready,
      output in_ready, A, B, C, D, W, X, Y, Z,
      output out_valid, ptr
   );

endinterface

// File: rtl/dmux_slot.sv
// One-entry channel buffer; a load in the same cycle as a pop
// wins, so the channel can stream one word per cycle.
module dmux_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             pop,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dmux8way16_buf.sv
// Registered 8-way demultiplexer: steers IN to one of eight
// one-entry buffers, by explicit select or round-robin pointer.
module dmux8way16_buf
   import xiphos_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input logic           clk,
   input logic           reset,
   dmux8way16_buf_if.slave bus
);

   chan_t            sel;
   chan_t            ptr_q;
   logic             accept;
   logic [NCH-1:0]   load;
   logic [NCH-1:0]   valid;
   logic [WIDTH-1:0] q [NCH];

   assign sel = bus.mode ? ptr_q : bus.s;

   // Readiness looks only at the targeted channel
   assign bus.in_ready = !reset
                       && (!valid[sel] || bus.out_ready[sel]);
   assign accept = bus.in_valid && bus.in_ready;
   assign load   = accept ? (NCH'(1) << sel) : '0;

   always_ff @(posedge clk) begin
      if (reset)
         ptr_q <= CH_A;
      else if (accept && bus.mode)
         ptr_q <= ptr_q + 3'd1;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_slot
      dmux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk   (clk),
         .reset (reset),
         .load  (load[i]),
         .d     (bus.IN),
         .pop   (bus.out_ready[i]),
         .q     (q[i]),
         .valid (valid[i])
      );
   end

   assign bus.A         = q[CH_A];
   assign bus.B         = q[CH_B];
   assign bus.C         = q[CH_C];
   assign bus.D         = q[CH_D];
   assign bus.W         = q[CH_W];
   assign bus.X         = q[CH_X];
   assign bus.Y         = q[CH_Y];
   assign bus.Z         = q[CH_Z];
   assign bus.out_valid = valid;
   assign bus.ptr       = ptr_q;

endmodule
